// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Purpose  : Shared types and constants for the bit-serial subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

  // Narrowest operand the serial datapath is meant to handle.
  localparam int unsigned MIN_WIDTH = 2;

  // Controller states, explicitly encoded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fs_cell
//  Purpose  : One-bit full subtractor (x - y - c), borrow out on c_next.
//  Revision : 1.0  initial release
// ============================================================================
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic c_next
);

  // Difference bit and borrow generation for a single bit position.
  always_comb begin
    d      = x ^ y ^ c;
    c_next = (~x & y) | (~x & c) | (y & c);
  end

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub
//  Purpose  : Bit-serial subtractor, diff = a - b - bin, LSB first, one bit
//             per clock through a single full-subtractor cell.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Counter needs one spare bit so it can reach WIDTH without wrapping.
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // minuend shifter; result bits enter at the top
  logic [WIDTH-1:0] b_q, b_d;        // subtrahend shifter
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic cell_d;
  logic cell_c_next;
  logic accept;
  logic last;

  // Start is honoured whenever no operation is in flight (IDLE or DONE).
  assign accept = start && (state_q != RUN);
  // True in the RUN cycle whose closing edge processes the MSB.
  assign last   = (state_q == RUN) && (cnt_q == LAST_BIT);

  // The only per-bit arithmetic: current LSBs plus the stored borrow.
  fs_cell u_fs_cell (
    .x      (a_q[0]),
    .y      (b_q[0]),
    .c      (borrow_q),
    .d      (cell_d),
    .c_next (cell_c_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Datapath next values: capture on accept, shift one bit per RUN cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bin;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      a_d      = {cell_d, a_q[WIDTH-1:1]};
      b_d      = {1'b0, b_q[WIDTH-1:1]};
      borrow_d = cell_c_next;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        // Publish all results together; borrow_q is the borrow into the MSB.
        diff_d = {cell_d, a_q[WIDTH-1:1]};
        bout_d = cell_c_next;
        ovf_d  = borrow_q ^ cell_c_next;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub
//  Purpose  : Self-checking bench for serial_sub (WIDTH = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present operands at the falling edge, let the next rising edge capture,
  // then scramble the inputs so late changes would corrupt a wrong design.
  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
  endtask

  // Count edges from the capture edge until done; results must not move while busy.
  task automatic wait_done(input int already, output int lat, output int hold_err);
    logic [9:0] held;
    held = {diff, bout, ovf};
    hold_err = 0;
    lat = already;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy && ({diff, bout, ovf} !== held)) hold_err++;
    end while (!done && lat < 20);
  endtask

  task automatic check_result(input string tag, input int lat, input int hold_err,
                              input logic [7:0] d, input logic bo, input logic ov);
    chk({tag, " latency"}, lat, 8);
    chk({tag, " hold"}, hold_err, 0);
    chk({tag, " diff"}, diff, d);
    chk({tag, " bout"}, bout, bo);
    chk({tag, " ovf"}, ovf, ov);
    chk({tag, " busy_in_done"}, busy, 0);
  endtask

  initial begin
    int lat;
    int herr;
    int seen_done;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'h01, 1'b1, 8'hFD, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    chk("reset ovf", ovf, 0);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      chk($sformatf("v%0d busy_run", i), busy, 1);
      wait_done(0, lat, herr);
      check_result($sformatf("v%0d", i), lat, herr, vecs[i].d, vecs[i].bo, vecs[i].ov);
      @(posedge clk); #1;
      chk($sformatf("v%0d done_pulse", i), done, 0);
      chk($sformatf("v%0d diff_after", i), diff, vecs[i].d);
    end

    // Start during RUN is ignored; start in DONE chains straight into RUN.
    start_op(8'h05, 8'h03, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 8'h40; b = 8'h10; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, herr);
    check_result("ignore", lat, herr, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h00; b = 8'h00;
    chk("b2b busy", busy, 1);
    chk("b2b done_low", done, 0);
    wait_done(0, lat, herr);
    check_result("b2b", lat, herr, 8'hF0, 1'b1, 1'b0);

    // Reset in the middle of RUN aborts and clears everything at once.
    start_op(8'h80, 8'h01, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort bout", bout, 0);
    chk("abort ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("abort no_done", seen_done, 0);

    // First operation after reset behaves normally.
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(0, lat, herr);
    check_result("post_reset", lat, herr, 8'h02, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
